// File: rtl/lsu_data_mem.sv
// rtl/lsu_data_mem.sv - load/store data memory with valid/ready handshakes and fault checking
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (one transaction outstanding)
//   req_wen                  1 = store, 0 = load
//   req_addr                 byte address
//   req_size                 0 = byte, 1 = half, 2 = word, 3 = double
//   req_signed               sign-extend load result
//   req_wdata                store data, LSB-justified
//   resp_valid/resp_ready    response handshake
//   resp_rdata               extended load data; 0 for stores and faults
//   resp_err                 out of range, illegal size, or misaligned (trap build)
//
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned accesses fault; otherwise
// the lane is aligned down to the access size.

module lsu_data_mem #(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 64,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
  parameter int                LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int                NB        = DATA_W / 8;
  localparam int                LB        = $clog2(NB);
  localparam int                IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH * NB);
  localparam logic [3:0]        LAT_M1    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] off;
  logic [LB-1:0]     lane, lane_eff, sz_mask;
  logic [IW-1:0]     idx;
  logic              range_err, size_err, misal, acc_err;
  logic              accept, we, full, sign_bit;
  logic [NB-1:0]     bmask;
  logic [DATA_W-1:0] rword, shifted, wmask, ld_data, wdata_sh;
  int                nbytes, wbits;

  assign accept = req_valid && req_ready_q && !rst;
  assign we     = accept && req_wen && !acc_err;

  // Address decode, fault detection and load-data extraction.
  always_comb begin
    off       = req_addr - BASE_ADDR;
    lane      = off[LB-1:0];
    idx       = off[LB +: IW];
    sz_mask   = LB'((4'd1 << req_size) - 4'd1);
    range_err = (off >= MEM_BYTES);
    size_err  = (DATA_W == 32) && (req_size == 2'd3);
    misal     = (lane & sz_mask) != '0;
`ifdef LSU_MISALIGN_TRAP_EN
    acc_err   = range_err || size_err || misal;
    lane_eff  = lane;
`else
    acc_err   = range_err || size_err;
    lane_eff  = lane & ~sz_mask;
`endif
    nbytes = 1 << req_size;
    wbits  = 8 << req_size;
    full   = int'(req_size) >= LB;
    for (int b = 0; b < NB; b++) begin
      bmask[b] = (b >= int'(lane_eff)) && (b < int'(lane_eff) + nbytes);
    end
    for (int i = 0; i < DATA_W; i++) begin
      wmask[i] = full || (i < wbits);
    end
    wdata_sh = req_wdata << {lane_eff, 3'b000};
    rword    = mem[idx];
    shifted  = rword >> {lane_eff, 3'b000};
    // MSB of the selected slice is the one bit in wmask not present in wmask>>1.
    sign_bit = |(shifted & wmask & ~(wmask >> 1));
    ld_data  = (shifted & wmask) |
               ((req_signed && sign_bit && !full) ? ~wmask : '0);
  end

  // Stores commit at the accept edge; only masked bytes are written.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (bmask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rdata_d     = (req_wen || acc_err) ? '0 : ld_data;
          err_d       = acc_err;
          req_ready_d = 1'b0;
          if (LATENCY == 1) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

`ifndef LSU_MISALIGN_TRAP_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (accept && misal && !range_err && !size_err)
      $display("lsu_data_mem: warning: misaligned access at 0x%h aligned down", req_addr);
  end
`endif
`endif

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb/tb_lsu_data_mem.sv - directed self-checking bench for lsu_data_mem

module tb_lsu_data_mem;

  localparam int          DW    = 64;
  localparam int          AW    = 64;
  localparam int          DEPTH = 256;
  localparam int          LAT   = 3;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  int checks = 0;
  int errors = 0;

  lsu_data_mem #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Drives one transaction from a negedge; returns response and observed latency.
  task automatic xact(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [63:0] wdata,
                      output logic [63:0] rdata, output logic err, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_wen = wen; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = '1; req_wdata = '1; req_size = 2'd3; req_signed = ~sgn; req_wen = ~wen;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load_dword();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h8000_0008, 2'd3, 1'b0, 64'h1122334455667788, rd, er, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (rd !== 64'd0 || er !== 1'b0) begin errors++; $display("FAIL store_resp: got rdata=%h err=%b want 0 0", rd, er); end
    xact(1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
      errors++; $display("FAIL load_dword: got rdata=%h err=%b want 1122334455667788 0", rd, er);
    end
  endtask

  task automatic test_byte_lanes();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h8000_0000, 2'd3, 1'b0, 64'd0, rd, er, lat);
    xact(1'b1, 64'h8000_0003, 2'd0, 1'b0, 64'h00000000000000A5, rd, er, lat);
    xact(1'b0, 64'h8000_0000, 2'd2, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h00000000A5000000 || er !== 1'b0) begin
      errors++; $display("FAIL word_unsigned: got rdata=%h err=%b want 00000000a5000000 0", rd, er);
    end
    xact(1'b0, 64'h8000_0003, 2'd0, 1'b1, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFFA5 || er !== 1'b0) begin
      errors++; $display("FAIL byte_signed: got rdata=%h err=%b want ffffffffffffffa5 0", rd, er);
    end
    xact(1'b0, 64'h8000_0003, 2'd0, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h00000000000000A5) begin errors++; $display("FAIL byte_unsigned: got %h want a5", rd); end
    xact(1'b0, 64'h8000_0002, 2'd1, 1'b1, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFA500) begin errors++; $display("FAIL half_signed: got %h want ffffffffffffa500", rd); end
  endtask

  task automatic test_range();
    logic [63:0] rd; logic er; int lat;
    xact(1'b0, 64'h7FFF_FFF8, 2'd3, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'd0 || er !== 1'b1) begin errors++; $display("FAIL range_below: got rdata=%h err=%b want 0 1", rd, er); end
    xact(1'b0, BASE + 64'(DEPTH * 8), 2'd3, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'd0 || er !== 1'b1) begin errors++; $display("FAIL range_above: got rdata=%h err=%b want 0 1", rd, er); end
    // This address would alias word 0 if the index were used despite the fault.
    xact(1'b1, BASE + 64'(DEPTH * 8), 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
    checks++;
    if (rd !== 64'd0 || er !== 1'b1) begin errors++; $display("FAIL range_store: got rdata=%h err=%b want 0 1", rd, er); end
    xact(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h00000000A5000000) begin errors++; $display("FAIL range_ram_intact: got %h want 00000000a5000000", rd); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er; int lat;
    int w;
    req_wen = 1'b0; req_addr = 64'h8000_0008; req_size = 2'd3; req_signed = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!resp_valid && w < 40) begin @(negedge clk); w++; end
    // A competing store is offered the whole time the response is stalled.
    req_valid = 1'b1; req_wen = 1'b1; req_wdata = 64'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122334455667788 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got valid=%b rdata=%h err=%b ready=%b want 1 1122334455667788 0 0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: got valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
    xact(1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL stall_no_accept: got %h want 1122334455667788", rd); end
  endtask

  task automatic test_misalign();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h8000_0000, 2'd1, 1'b0, 64'h000000000000BEEF, rd, er, lat);
    xact(1'b0, 64'h8000_0001, 2'd1, 1'b0, 64'd0, rd, er, lat);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (rd !== 64'd0 || er !== 1'b1) begin errors++; $display("FAIL misalign_half: got rdata=%h err=%b want 0 1", rd, er); end
`else
    if (rd !== 64'h000000000000BEEF || er !== 1'b0) begin
      errors++; $display("FAIL misalign_half: got rdata=%h err=%b want beef 0", rd, er);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'hCAFEBABEDEADBEEF, rd, er, lat);
    // Store accepted, then reset while it waits for its response.
    req_wen = 1'b1; req_addr = 64'h8000_0018; req_size = 2'd3; req_wdata = 64'h0123456789ABCDEF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_store_wait: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
    end
    // Load in WAIT, reset, then confirm no stale response ever appears.
    req_wen = 1'b0; req_addr = 64'h8000_0010; req_size = 2'd3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_load_wait: got ready=%b valid=%b want 1 0", req_ready, resp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resp: cycle %0d got valid=%b want 0", i, resp_valid); end
    end
    xact(1'b0, 64'h8000_0018, 2'd3, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin
      errors++; $display("FAIL rst_store_kept: got rdata=%h err=%b want 0123456789abcdef 0", rd, er);
    end
    xact(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hCAFEBABEDEADBEEF) begin errors++; $display("FAIL rst_prior_store: got %h want cafebabedeadbeef", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load_dword();
    test_byte_lanes();
    test_range();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
